// File: rtl/scan_pkg.sv
// Shared types and defaults for the line-sensor readout sequencer.
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SH     = 3'd1,
        ST_DUMMY  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam int DEF_SH_CYCLES    = 8;
    localparam int DEF_DUMMY_PIXELS = 32;
    localparam int DEF_MIN_GAP      = 4;
    localparam int PHASE_W          = 16;

    // A phase of N cycles loads N-1 so the zero flag marks its final cycle.
    function automatic logic [PHASE_W-1:0] phase_load(input logic [PHASE_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - 1'b1;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero, load has priority.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         rx_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/scan_line_sequencer.sv
// Frame sequencer for line-sensor readout: SH pulse, dark-pixel skip, active
// pixel window and an enforced inter-line gap, repeated for cfg_lines lines.
module scan_line_sequencer
    import scan_pkg::*;
#(
    parameter int PIX_W        = 16,
    parameter int LINE_W       = 16,
    parameter int SH_CYCLES    = DEF_SH_CYCLES,
    parameter int DUMMY_PIXELS = DEF_DUMMY_PIXELS,
    parameter int MIN_GAP      = DEF_MIN_GAP
) (
    input  logic              rx_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [PIX_W-1:0]  cfg_pixels,
    input  logic [LINE_W-1:0] cfg_lines,
    input  logic [15:0]       cfg_gap,
    output logic              sensor_sh,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_index,
    output logic [LINE_W-1:0] line_index,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam logic [PHASE_W-1:0] SH_LOAD    = PHASE_W'(SH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] DUMMY_LOAD = (DUMMY_PIXELS > 0) ? PHASE_W'(DUMMY_PIXELS - 1) : '0;
    localparam logic [PHASE_W-1:0] MIN_GAP_W  = PHASE_W'(MIN_GAP);

    state_t              state_reg, state_next;
    logic [PIX_W-1:0]    pixels_reg, pixels_next;
    logic [LINE_W-1:0]   lines_reg, lines_next;
    logic [PHASE_W-1:0]  gap_eff_reg, gap_eff_next;
    logic [PIX_W-1:0]    pix_index_reg, pix_index_next;
    logic [LINE_W-1:0]   line_index_reg, line_index_next;
    logic                sensor_sh_reg, pix_valid_reg, busy_reg;
    logic                frame_done_reg, frame_done_next;
    logic                cfg_err_reg, cfg_err_next;

    logic                cnt_load, cnt_dec, cnt_zero;
    logic [PHASE_W-1:0]  cnt_load_value;

    seq_down_counter #(.W(PHASE_W)) u_phase_cnt (
        .rx_clk     (rx_clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_next      = state_reg;
        pixels_next     = pixels_reg;
        lines_next      = lines_reg;
        gap_eff_next    = gap_eff_reg;
        pix_index_next  = '0;
        line_index_next = line_index_reg;
        frame_done_next = 1'b0;
        cfg_err_next    = 1'b0;
        cnt_load        = 1'b0;
        cnt_load_value  = '0;
        cnt_dec         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_pixels == '0) || (cfg_lines == '0)) begin
                        cfg_err_next = 1'b1;
                    end else begin
                        pixels_next     = cfg_pixels;
                        lines_next      = cfg_lines;
                        gap_eff_next    = (cfg_gap < MIN_GAP_W) ? MIN_GAP_W : cfg_gap;
                        line_index_next = '0;
                        state_next      = ST_SH;
                        cnt_load        = 1'b1;
                        cnt_load_value  = SH_LOAD;
                    end
                end
            end
            ST_SH: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (DUMMY_PIXELS == 0) begin
                    state_next = ST_ACTIVE;
                end else begin
                    state_next     = ST_DUMMY;
                    cnt_load       = 1'b1;
                    cnt_load_value = DUMMY_LOAD;
                end
            end
            ST_DUMMY: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pix_index_reg == pixels_reg - 1'b1) begin
                    state_next     = ST_GAP;
                    cnt_load       = 1'b1;
                    cnt_load_value = phase_load(gap_eff_reg);
                end else begin
                    pix_index_next = pix_index_reg + 1'b1;
                end
            end
            ST_GAP: begin
                // hold only matters once the minimum gap has elapsed
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (!hold) begin
                    if (line_index_reg == lines_reg - 1'b1) begin
                        state_next      = ST_IDLE;
                        frame_done_next = 1'b1;
                        line_index_next = '0;
                    end else begin
                        state_next      = ST_SH;
                        line_index_next = line_index_reg + 1'b1;
                        cnt_load        = 1'b1;
                        cnt_load_value  = SH_LOAD;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort && (state_reg != ST_IDLE)) begin
            state_next      = ST_IDLE;
            pix_index_next  = '0;
            line_index_next = '0;
            frame_done_next = 1'b0;
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pixels_reg     <= '0;
            lines_reg      <= '0;
            gap_eff_reg    <= '0;
            pix_index_reg  <= '0;
            line_index_reg <= '0;
            sensor_sh_reg  <= 1'b0;
            pix_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pixels_reg     <= pixels_next;
            lines_reg      <= lines_next;
            gap_eff_reg    <= gap_eff_next;
            pix_index_reg  <= pix_index_next;
            line_index_reg <= line_index_next;
            sensor_sh_reg  <= (state_next == ST_SH);
            pix_valid_reg  <= (state_next == ST_ACTIVE);
            busy_reg       <= (state_next != ST_IDLE);
            frame_done_reg <= frame_done_next;
            cfg_err_reg    <= cfg_err_next;
        end
    end

    assign sensor_sh  = sensor_sh_reg;
    assign pix_valid  = pix_valid_reg;
    assign pix_index  = pix_index_reg;
    assign line_index = line_index_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign cfg_err    = cfg_err_reg;

endmodule
